// File: rtl/des_block_packer.sv
// Byte-to-block packer feeding the DES plaintext input: fills 64-bit blocks MSB-lane first,
// pads the final block of each message (PKCS#5 or zero-fill) and holds each block until accepted.
module des_block_packer #(
  parameter bit PAD_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  input  logic        i_byte_last,
  output logic        o_byte_ready,
  output logic [63:0] o_block,
  output logic        o_block_valid,
  output logic        o_block_last,
  input  logic        i_block_ready,
  output logic [15:0] o_blocks_out
);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_OUT    = 2'd1,
    S_PADOUT = 2'd2
  } state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic        pad_pending_q;
  logic [63:0] block_q;
  logic        valid_q;
  logic        last_q;
  logic [15:0] blocks_q;

  logic [63:0] block_d;
  logic [7:0]  pad_byte_s;

  // Next block image: current lane gets the byte, later lanes get padding on the last byte
  always_comb begin
    pad_byte_s = PAD_EN ? (8'd7 - {5'd0, cnt_q}) : 8'h00;
    block_d    = block_q;
    for (int k = 0; k < 8; k++) begin
      if (3'(k) == cnt_q) begin
        block_d[63-8*k -: 8] = i_byte;
      end else if ((3'(k) > cnt_q) && i_byte_last) begin
        block_d[63-8*k -: 8] = pad_byte_s;
      end else begin
        block_d[63-8*k -: 8] = block_q[63-8*k -: 8];
      end
    end
  end

  // Packer FSM with registered block outputs and handshake counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_FILL;
      cnt_q         <= 3'd0;
      pad_pending_q <= 1'b0;
      block_q       <= 64'd0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      blocks_q      <= 16'd0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (i_byte_valid) begin
            block_q <= block_d;
            if (i_byte_last) begin
              state_q <= S_OUT;
              valid_q <= 1'b1;
              cnt_q   <= 3'd0;
              // A full final block still needs a whole pad block after it
              if ((cnt_q == 3'd7) && PAD_EN) begin
                last_q        <= 1'b0;
                pad_pending_q <= 1'b1;
              end else begin
                last_q <= 1'b1;
              end
            end else if (cnt_q == 3'd7) begin
              state_q <= S_OUT;
              valid_q <= 1'b1;
              last_q  <= 1'b0;
              cnt_q   <= 3'd0;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        S_OUT: begin
          if (i_block_ready) begin
            blocks_q <= blocks_q + 16'd1;
            if (pad_pending_q) begin
              block_q       <= 64'h0808080808080808;
              last_q        <= 1'b1;
              pad_pending_q <= 1'b0;
              state_q       <= S_PADOUT;
            end else begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= S_FILL;
            end
          end
        end
        S_PADOUT: begin
          if (i_block_ready) begin
            blocks_q <= blocks_q + 16'd1;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            state_q  <= S_FILL;
          end
        end
        default: begin
          state_q <= S_FILL;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_byte_ready  = (state_q == S_FILL) && !i_rst;
  assign o_block       = block_q;
  assign o_block_valid = valid_q;
  assign o_block_last  = last_q;
  assign o_blocks_out  = blocks_q;

endmodule
